signed_add_arbiter: RTL and testbench
=====================================

// Module: signed_add_arbiter
// PURPOSE
//  Shares one signed WL-bit adder between two pipeline requesters (0: branch-target calc,
//  1: load/store effective-address calc). Valid/ready handshake per port, round-robin grant,
//  one registered result slot tagged with the winner's ID. Sits in EX beside the main ALU.
// PARAMETERS
//  WL   15   operand width (signed, two's complement); result is WL+1 bits
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous reset, active-high
//  req_vld    in   2     request valid, bit i = requester i
//  req_rdy    out  2     request accepted this cycle (bit i)
//  a0, b0     in   WL    signed operands, requester 0
//  a1, b1     in   WL    signed operands, requester 1
//  res_vld    out  1     result slot holds valid data
//  res_rdy    in   1     consumer takes result this cycle
//  res_sum    out  WL+1  signed sum of granted operands
//  res_id     out  1     requester that produced res_sum
//  res_ovf    out  1     result clamped (SIGNED_ADD_SAT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async, immediate): res_vld=0, res_sum=0, res_id=0, res_ovf=0, prio=0, state EMPTY.
//  - States: EMPTY (slot free) / FULL (slot holds result). free = EMPTY | (FULL & res_rdy).
//  - Grant only when free: one vld -> grant it; both -> grant prio; none -> no grant.
//    req_rdy is one-hot or zero, combinational from req_vld, prio, state, res_rdy.
//  - Transfer on req_vld[i] & req_rdy[i]: next edge loads res_sum = sext(ai)+sext(bi),
//    res_id=i, res_vld=1, state FULL. Latency 1 cycle accept->res_vld.
//  - prio <= ~granted_id after every grant; unchanged on cycles without a grant.
//  - FULL & res_rdy & new grant: slot replaced same edge, res_vld stays 1 (back-to-back, 1/clk).
//  - FULL & res_rdy & no grant: -> EMPTY, res_vld=0; res_sum/res_id hold last value.
//  - FULL & !res_rdy: all outputs hold, req_rdy=0 (backpressure).
//  - Arithmetic: both operands sign-extended to WL+1 before add; never overflows in WL+1.
//  - Requester must hold ai/bi stable while req_vld[i]=1 & !req_rdy[i].
//  - Reset asserted mid-transfer discards the pending result; no grant survives reset.
// CONFIGURATION
//  SIGNED_ADD_SAT_EN defined: sum clamped to WL-bit range [-2^(WL-1), 2^(WL-1)-1],
//    sign-extended into res_sum; res_ovf=1 when clamping occurred, registered with res_sum.
//  Undefined: full WL+1-bit sum passed through; res_ovf constant 0.
// STRUCTURE
//  Package sadd_arb_pkg: localparam ID_W=1, state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1),
//    saturation bounds as functions of WL.
//  Sub-module rr_arb2: 2-way round-robin grant (req[1:0], en, prio -> gnt[1:0], gnt_id);
//    pointer register stays in the top level. Adder and result register stay in the top level.
// TESTING  (WL=15)
//  1. Reset mid-FULL, res_rdy=0: rst pulse -> res_vld=0, res_sum=0, prio=0 immediately.
//  2. Only req0: a0=100, b0=-300, res_rdy=1 -> next cycle res_vld=1, res_sum=-200, res_id=0.
//  3. Both valid every cycle, res_rdy=1 -> grants alternate 0,1,0,1; one result per clock.
//  4. res_rdy=0 for 3 cycles with both requesting -> req_rdy=0, res_* stable for 3 cycles;
//     on res_rdy=1, next grant taken same cycle, res_vld never drops.
//  5. a1=16383, b1=1: no macro -> res_sum=16384, res_ovf=0; with SIGNED_ADD_SAT_EN ->
//     res_sum=16383, res_ovf=1.
//  6. a0=-16384, b0=-16384: no macro -> -32768; with macro -> -16384, res_ovf=1.

Source files
------------

// File: rtl/sadd_arb_pkg.sv
// Shared types and constants for signed_add_arbiter: ID width, slot state encoding and
// saturation bounds used when SIGNED_ADD_SAT_EN is defined.
package sadd_arb_pkg;

  localparam int unsigned ID_W = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Largest value representable in a wl-bit two's complement word.
  function automatic int sat_max(input int unsigned wl);
    return (1 << (wl - 1)) - 1;
  endfunction

  // Smallest value representable in a wl-bit two's complement word.
  function automatic int sat_min(input int unsigned wl);
    return -(1 << (wl - 1));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: with both requests present, prio_i picks the winner.
// The priority pointer itself lives in the parent.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_o    = 2'b00;
    gnt_id_o = 1'b0;
    if (en_i) begin
      unique case (req_i)
        2'b01: begin
          gnt_o    = 2'b01;
          gnt_id_o = 1'b0;
        end
        2'b10: begin
          gnt_o    = 2'b10;
          gnt_id_o = 1'b1;
        end
        2'b11: begin
          gnt_o    = prio_i ? 2'b10 : 2'b01;
          gnt_id_o = prio_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/signed_add_arbiter.sv
// One signed adder shared by two requesters behind a round-robin grant and a single result
// slot. Define SIGNED_ADD_SAT_EN to clamp the sum to the WL-bit range and flag res_ovf_o.
module signed_add_arbiter
  import sadd_arb_pkg::*;
#(
  parameter int unsigned WL = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_vld_i,
  output logic [1:0]            req_rdy_o,
  input  logic [WL-1:0]         a0_i,
  input  logic [WL-1:0]         b0_i,
  input  logic [WL-1:0]         a1_i,
  input  logic [WL-1:0]         b1_i,
  output logic                  res_vld_o,
  input  logic                  res_rdy_i,
  output logic [WL:0]           res_sum_o,
  output logic [ID_W-1:0]       res_id_o,
  output logic                  res_ovf_o
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [WL:0]       sum_q, sum_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              free;
  logic              gnt_any;
  logic [1:0]        gnt;
  logic              gnt_id;
  logic [WL-1:0]     a_sel, b_sel;
  logic signed [WL:0] sum_full;
  logic signed [WL:0] sum_res;

  // Slot can take a new result when empty or when the current one leaves this cycle.
  assign free = (state_q == ST_EMPTY) || res_rdy_i;

  rr_arb2 u_rr_arb2 (
    .req_i    (req_vld_i),
    .en_i     (free),
    .prio_i   (prio_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign gnt_any   = |gnt;
  assign req_rdy_o = gnt;

  assign a_sel    = gnt_id ? a1_i : a0_i;
  assign b_sel    = gnt_id ? b1_i : b0_i;
  assign sum_full = {a_sel[WL-1], a_sel} + {b_sel[WL-1], b_sel};

`ifdef SIGNED_ADD_SAT_EN
  localparam logic signed [WL:0] SatHi = (WL+1)'(sat_max(WL));
  localparam logic signed [WL:0] SatLo = (WL+1)'(sat_min(WL));

  logic ovf_d, ovf_q;

  always_comb begin
    sum_res = sum_full;
    ovf_d   = 1'b0;
    if (sum_full > SatHi) begin
      sum_res = SatHi;
      ovf_d   = 1'b1;
    end else if (sum_full < SatLo) begin
      sum_res = SatLo;
      ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (gnt_any) begin
      ovf_q <= ovf_d;
    end
  end

  assign res_ovf_o = ovf_q;
`else
  assign sum_res   = sum_full;
  assign res_ovf_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (gnt_any) begin
      state_d = ST_FULL;
      prio_d  = ~gnt_id;
      sum_d   = sum_res;
      id_d    = gnt_id;
    end else if ((state_q == ST_FULL) && res_rdy_i) begin
      // Result drained with nothing to replace it; sum/id keep their last value.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      prio_q  <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  assign res_vld_o = (state_q == ST_FULL);
  assign res_sum_o = sum_q;
  assign res_id_o  = id_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Scoreboard bench for signed_add_arbiter: directed vectors push expected results on accept,
// a monitor pops and compares whenever a result is consumed.
module tb_signed_add_arbiter;

  localparam int unsigned WL = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_vld;
  logic [1:0]    req_rdy;
  logic [WL-1:0] a0, b0, a1, b1;
  logic          res_vld;
  logic          res_rdy;
  logic [WL:0]   res_sum;
  logic [0:0]    res_id;
  logic          res_ovf;

  typedef struct packed {
    logic [WL:0] sum;
    logic        id;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  logic [WL:0] exp0_sum, exp1_sum;
  logic        exp0_ovf, exp1_ovf;

  signed_add_arbiter #(.WL(WL)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_vld_i (req_vld),
    .req_rdy_o (req_rdy),
    .a0_i      (a0),
    .b0_i      (b0),
    .a1_i      (a1),
    .b1_i      (b1),
    .res_vld_o (res_vld),
    .res_rdy_i (res_rdy),
    .res_sum_o (res_sum),
    .res_id_o  (res_id),
    .res_ovf_o (res_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; checks the grant and records any accepted request.
  task automatic step(input logic [1:0] vld, input logic rdy, input logic [1:0] exp_gnt,
                      input string name);
    @(negedge clk);
    req_vld = vld;
    res_rdy = rdy;
    #2;
    check($sformatf("%s_gnt", name), 32'(req_rdy), 32'(exp_gnt));
    if (req_vld[0] && req_rdy[0]) sb.push_back('{sum: exp0_sum, id: 1'b0, ovf: exp0_ovf});
    if (req_vld[1] && req_rdy[1]) sb.push_back('{sum: exp1_sum, id: 1'b1, ovf: exp1_ovf});
  endtask

  // Monitor: just before each rising edge, a result with res_rdy high is being consumed.
  always begin
    @(negedge clk);
    #4;
    if (!rst && res_vld && res_rdy) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got result 0x%0h, expected none", res_sum);
      end else begin
        e = sb.pop_front();
        n_pop++;
        check("res_sum", 32'(res_sum), 32'(e.sum));
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_vld = 2'b00; res_rdy = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    exp0_sum = '0; exp1_sum = '0; exp0_ovf = 1'b0; exp1_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_vld", 32'(res_vld), 32'd0);
    check("rst_sum", 32'(res_sum), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_ovf", 32'(res_ovf), 32'd0);
    check("rst_gnt", 32'(req_rdy), 32'd0);

    // Single requester 0: 100 + -300
    a0 = 15'(100); b0 = 15'(-300); exp0_sum = 16'(-200); exp0_ovf = 1'b0;
    step(2'b01, 1'b1, 2'b01, "t2_acc");
    step(2'b00, 1'b1, 2'b00, "t2_drain");
    check("t2_vld", 32'(res_vld), 32'd1);

    // Fill slot under backpressure, then reset asynchronously
    step(2'b01, 1'b0, 2'b01, "t1_fill");
    step(2'b00, 1'b0, 2'b00, "t1_hold");
    check("t1_vld_full", 32'(res_vld), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t1_rst_vld", 32'(res_vld), 32'd0);
    check("t1_rst_sum", 32'(res_sum), 32'd0);
    check("t1_rst_id", 32'(res_id), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    // Both requesting, consumer always ready: grants alternate starting from 0
    a1 = 15'(5); b1 = 15'(7); exp1_sum = 16'(12); exp1_ovf = 1'b0;
    step(2'b11, 1'b1, 2'b01, "t3_g0");
    step(2'b11, 1'b1, 2'b10, "t3_g1");
    check("t3_vld1", 32'(res_vld), 32'd1);
    step(2'b11, 1'b1, 2'b01, "t3_g2");
    check("t3_vld2", 32'(res_vld), 32'd1);
    step(2'b11, 1'b1, 2'b10, "t3_g3");
    check("t3_vld3", 32'(res_vld), 32'd1);

    // Backpressure for 3 cycles: no grants, slot (12 from requester 1) holds
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b0, 2'b00, "t4_bp");
      check("t4_bp_vld", 32'(res_vld), 32'd1);
      check("t4_bp_sum", 32'(res_sum), 32'd12);
      check("t4_bp_id", 32'(res_id), 32'd1);
    end
    step(2'b11, 1'b1, 2'b01, "t4_resume");
    check("t4_resume_vld", 32'(res_vld), 32'd1);
    step(2'b11, 1'b1, 2'b10, "t4_next");
    check("t4_next_vld", 32'(res_vld), 32'd1);
    step(2'b00, 1'b1, 2'b00, "t4_drain");
    step(2'b00, 1'b1, 2'b00, "t4_empty");
    check("t4_empty_vld", 32'(res_vld), 32'd0);
    check("t4_hold_sum", 32'(res_sum), 32'd12);
    check("t4_hold_id", 32'(res_id), 32'd1);

    // Positive edge of the range: 16383 + 1
    a1 = 15'(16383); b1 = 15'(1);
`ifdef SIGNED_ADD_SAT_EN
    exp1_sum = 16'(16383); exp1_ovf = 1'b1;
`else
    exp1_sum = 16'(16384); exp1_ovf = 1'b0;
`endif
    step(2'b10, 1'b1, 2'b10, "t5_acc");
    step(2'b00, 1'b1, 2'b00, "t5_drain");

    // Negative edge of the range: -16384 + -16384
    a0 = 15'(-16384); b0 = 15'(-16384);
`ifdef SIGNED_ADD_SAT_EN
    exp0_sum = 16'(-16384); exp0_ovf = 1'b1;
`else
    exp0_sum = 16'(-32768); exp0_ovf = 1'b0;
`endif
    step(2'b01, 1'b1, 2'b01, "t6_acc");
    step(2'b00, 1'b1, 2'b00, "t6_drain");
    step(2'b00, 1'b1, 2'b00, "t6_idle");

    check("sb_left", 32'(sb.size()), 32'd0);
    check("result_count", 32'(n_pop), 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
